// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer: FSM encoding and
// the derived job sizes (weight count, output count).
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOADW,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    function automatic int kk_of(input int k);
        return k * k;
    endfunction

    // Valid (unpadded) output positions per axis, squared.
    function automatic int nout_of(input int img_w, input int k, input int stride);
        int n;
        n = (img_w - k) / stride + 1;
        return n * n;
    endfunction

endpackage

// File: rtl/conv_sched_if.sv
// Bundle of the sequencer's control, RAM and engine signals; master is the
// sequencer, slave is everything around it (RAMs, engine, host).
interface conv_sched_if #(
    parameter int AW = 10,
    parameter int DW = 32
) ();

    // All streams here are valid-only: a beat transfers in every cycle its
    // valid/enable is high and there is no back-pressure; RAM reads return
    // data exactly one cycle after the address.
    logic          iStart;
    logic          oBusy;
    logic          oDone;
    logic          oErr;
    logic [AW-1:0] oWAddr;
    logic [DW-1:0] iWData;
    logic [AW-1:0] oXAddr;
    logic [DW-1:0] iXData;
    logic [AW-1:0] oCnvADDR;
    logic [DW-1:0] oCnvW;
    logic          oCnvWren;
    logic [DW-1:0] oCnvX;
    logic          oCnvValid;
    logic [DW-1:0] iCnvY;
    logic          iCnvValid;
    logic [AW-1:0] oYAddr;
    logic [DW-1:0] oYData;
    logic          oYWren;
    conv_pkg::state_t dbg_state;

    modport master (
        input  iStart, iWData, iXData, iCnvY, iCnvValid,
        output oBusy, oDone, oErr, oWAddr, oXAddr, oCnvADDR, oCnvW, oCnvWren,
               oCnvX, oCnvValid, oYAddr, oYData, oYWren, dbg_state
    );

    modport slave (
        output iStart, iWData, iXData, iCnvY, iCnvValid,
        input  oBusy, oDone, oErr, oWAddr, oXAddr, oCnvADDR, oCnvW, oCnvWren,
               oCnvX, oCnvValid, oYAddr, oYData, oYWren, dbg_state
    );

endinterface

// File: rtl/conv_rd_pipe.sv
// Aligns a RAM read request (valid + tag) with the data that returns one
// cycle later; data is forced to zero whenever no read is landing.
module conv_rd_pipe #(
    parameter int TW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [TW-1:0] tag,
    input  logic [DW-1:0] rdata,
    output logic          vld,
    output logic [TW-1:0] vld_tag,
    output logic [DW-1:0] vld_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld     <= 1'b0;
            vld_tag <= '0;
        end else begin
            vld     <= req;
            vld_tag <= req ? tag : '0;
        end
    end

    assign vld_data = vld ? rdata : '0;

endmodule

// File: rtl/conv_sched.sv
// Job sequencer for the 5x5 convolution engine: weight load, raster pixel
// stream, result capture into the output RAM, drain watchdog.
module conv_sched
    import conv_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int K      = 5,
    parameter int STRIDE = 1,
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int TMO    = 64
) (
    input logic          iCLK,
    input logic          iRST,
    conv_sched_if.master bus
);

    localparam int KK   = kk_of(K);
    localparam int NPIX = IMG_W * IMG_W;
    localparam int NOUT = nout_of(IMG_W, K, STRIDE);
    localparam int YW   = AW + 1;
    localparam int WDW  = $clog2(TMO + 1);

    generate
        if (NPIX > (1 << AW) || NOUT > (1 << AW) || KK > (1 << AW)) begin : g_size_chk
            $error("conv_sched: image or output count does not fit in AW address bits");
        end
    endgenerate

    state_t        state;
    logic          w_req, x_req;
    logic [AW-1:0] w_addr, x_addr, y_addr;
    logic [YW-1:0] ycnt;
    logic [WDW-1:0] wd;
    logic          busy, done, err, y_wren;
    logic [DW-1:0] y_data;
    logic          cap;
    logic          x_tag_unused;

    // Results are taken whenever they show up while a job is streaming or
    // draining, up to NOUT of them; the engine latency is not assumed.
    assign cap = (state == STREAM || state == DRAIN) && bus.iCnvValid && (ycnt < YW'(NOUT));

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state  <= IDLE;
            w_req  <= 1'b0;
            x_req  <= 1'b0;
            w_addr <= '0;
            x_addr <= '0;
            y_addr <= '0;
            ycnt   <= '0;
            wd     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            y_wren <= 1'b0;
            y_data <= '0;
        end else begin
            y_wren <= 1'b0;
            done   <= 1'b0;
            if (cap) begin
                y_wren <= 1'b1;
                y_data <= bus.iCnvY;
                y_addr <= ycnt[AW-1:0];
                ycnt   <= ycnt + YW'(1);
            end
            case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        state  <= LOADW;
                        busy   <= 1'b1;
                        err    <= 1'b0;
                        w_req  <= 1'b1;
                        w_addr <= '0;
                        x_addr <= '0;
                        ycnt   <= '0;
                        wd     <= '0;
                    end
                end
                LOADW: begin
                    if (w_addr == AW'(KK - 1)) begin
                        state  <= STREAM;
                        w_req  <= 1'b0;
                        w_addr <= '0;
                        x_req  <= 1'b1;
                    end else begin
                        w_addr <= w_addr + AW'(1);
                    end
                end
                STREAM: begin
                    if (x_addr == AW'(NPIX - 1)) begin
                        state  <= DRAIN;
                        x_req  <= 1'b0;
                        x_addr <= '0;
                        wd     <= '0;
                    end else begin
                        x_addr <= x_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    // wd counts idle cycles since DRAIN entry or the last result.
                    if (ycnt == YW'(NOUT)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (cap) begin
                        wd <= '0;
                    end else if (wd == WDW'(TMO - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    conv_rd_pipe #(.TW(AW), .DW(DW)) u_wpipe (
        .clk      (iCLK),
        .rst      (iRST),
        .req      (w_req),
        .tag      (w_addr),
        .rdata    (bus.iWData),
        .vld      (bus.oCnvWren),
        .vld_tag  (bus.oCnvADDR),
        .vld_data (bus.oCnvW)
    );

    conv_rd_pipe #(.TW(1), .DW(DW)) u_xpipe (
        .clk      (iCLK),
        .rst      (iRST),
        .req      (x_req),
        .tag      (1'b0),
        .rdata    (bus.iXData),
        .vld      (bus.oCnvValid),
        .vld_tag  (x_tag_unused),
        .vld_data (bus.oCnvX)
    );

    assign bus.oBusy     = busy;
    assign bus.oDone     = done;
    assign bus.oErr      = err;
    assign bus.oWAddr    = w_addr;
    assign bus.oXAddr    = x_addr;
    assign bus.oYAddr    = y_addr;
    assign bus.oYData    = y_data;
    assign bus.oYWren    = y_wren;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: RAM and engine models around a default instance,
// plus a small STRIDE=2 / 8x8 instance for the short-job corner.
module tb_conv_sched;
    import conv_pkg::*;

    localparam int IMG  = 32;
    localparam int KS   = 5;
    localparam int ST   = 1;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int TMO  = 64;
    localparam int KK   = KS * KS;
    localparam int NPIX = IMG * IMG;
    localparam int NOW  = (IMG - KS) / ST + 1;
    localparam int NO   = NOW * NOW;

    logic clk;
    logic rst;

    conv_sched_if #(.AW(AW), .DW(DW)) bus ();
    conv_sched_if #(.AW(AW), .DW(DW)) bus2 ();

    conv_sched #(.IMG_W(IMG), .K(KS), .STRIDE(ST), .AW(AW), .DW(DW), .TMO(TMO)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus.master)
    );

    conv_sched #(.IMG_W(8), .K(5), .STRIDE(2), .AW(AW), .DW(DW), .TMO(TMO)) dut2 (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- RAM contents and golden convolution ----------------
    int wram[1024];
    int xram[1024];

    function automatic int sat32(input longint s);
        if (s > 64'sd2147483647) return 32'h7fffffff;
        if (s < -64'sd2147483648) return 32'h80000000;
        return int'(s);
    endfunction

    function automatic int golden(input int o);
        longint s;
        int r0, c0;
        s = 0;
        r0 = (o / NOW) * ST;
        c0 = (o % NOW) * ST;
        for (int a = 0; a < KS; a++)
            for (int b = 0; b < KS; b++)
                s += longint'(wram[a * KS + b]) * longint'(xram[(r0 + a) * IMG + c0 + b]);
        return sat32(s);
    endfunction

    always @(posedge clk) begin
        bus.iWData <= wram[bus.oWAddr];
        bus.iXData <= xram[bus.oXAddr];
    end

    // ---------------- engine model + scoreboard ----------------
    typedef struct {
        int due;
        int val;
    } res_t;

    res_t eng_q[$];
    int   eng_w[KK];
    int   eng_px[NPIX];
    int   eng_pcnt, eng_made;
    int   eng_lat = 3;
    int   eng_limit = 1 << 30;

    logic [31:0] exp_q[$];
    int job_id = 0, seen_id = 0;
    int cyc = 0;
    int wren_n, pix_n, y_n, done_n;
    int first_w_cyc, last_w_cyc, last_pix_cyc, last_y_cyc, err_rise_cyc;
    int first_y, second_y, last_yaddr;
    bit err_prev;
    int w2_n = 0, p2_n = 0, y2_n = 0, done2_n = 0;

    always @(negedge clk) begin
        cyc++;
        if (job_id != seen_id) begin
            seen_id = job_id;
            wren_n = 0; pix_n = 0; y_n = 0; done_n = 0;
            first_w_cyc = 0; last_w_cyc = 0; last_pix_cyc = 0; last_y_cyc = 0;
            err_rise_cyc = 0; first_y = 0; second_y = 0; last_yaddr = 0; err_prev = 0;
            exp_q.delete();
            for (int o = 0; o < NO; o++) exp_q.push_back(golden(o));
            eng_q.delete();
            eng_pcnt = 0;
            eng_made = 0;
        end

        if (bus.oCnvWren) begin
            if (wren_n == 0) first_w_cyc = cyc;
            last_w_cyc = cyc;
            check("cnv_addr", 32'(bus.oCnvADDR), wren_n);
            check("cnv_w", bus.oCnvW, wram[wren_n % KK]);
            wren_n++;
        end
        if (bus.oCnvValid) begin
            check("cnv_x", bus.oCnvX, xram[pix_n % NPIX]);
            pix_n++;
            last_pix_cyc = cyc;
        end
        if (bus.oYWren) begin
            check("y_addr", 32'(bus.oYAddr), y_n);
            if (exp_q.size() == 0) check("y_extra_write", 32'(y_n), NO);
            else check("y_data", bus.oYData, exp_q.pop_front());
            if (y_n == 0) first_y = bus.oYData;
            if (y_n == 1) second_y = bus.oYData;
            last_yaddr = 32'(bus.oYAddr);
            last_y_cyc = cyc;
            y_n++;
        end
        if (bus.oDone) done_n++;
        if (bus.oErr && !err_prev) err_rise_cyc = cyc;
        err_prev = bus.oErr;

        if (bus2.oCnvWren) w2_n++;
        if (bus2.oCnvValid) p2_n++;
        if (bus2.oYWren) begin
            check("s2_y_addr", 32'(bus2.oYAddr), y2_n);
            check("s2_y_data", bus2.oYData, 1000 + y2_n);
            y2_n++;
        end
        if (bus2.oDone) done2_n++;

        // Engine: collect weights and pixels, emit each completed window
        // after a fixed latency, with random idle cycles in between.
        if (rst) begin
            eng_q.delete();
            eng_pcnt = 0;
        end else begin
            if (bus.oCnvWren && bus.oCnvADDR < AW'(KK)) eng_w[bus.oCnvADDR] = bus.oCnvW;
            if (bus.oCnvValid) begin
                int r, c;
                longint s;
                eng_px[eng_pcnt] = bus.oCnvX;
                r = eng_pcnt / IMG;
                c = eng_pcnt % IMG;
                if (r >= KS - 1 && c >= KS - 1 && ((r - KS + 1) % ST) == 0 && ((c - KS + 1) % ST) == 0) begin
                    s = 0;
                    for (int a = 0; a < KS; a++)
                        for (int b = 0; b < KS; b++)
                            s += longint'(eng_w[a * KS + b]) *
                                 longint'(eng_px[(r - KS + 1 + a) * IMG + (c - KS + 1 + b)]);
                    eng_q.push_back('{due: cyc + eng_lat, val: sat32(s)});
                end
                eng_pcnt = (eng_pcnt + 1) % NPIX;
            end
        end
        bus.iCnvValid = 1'b0;
        bus.iCnvY     = '0;
        if (eng_q.size() > 0 && eng_q[0].due <= cyc && eng_made < eng_limit && $urandom_range(0, 3) != 0) begin
            res_t e;
            e = eng_q.pop_front();
            bus.iCnvValid = 1'b1;
            bus.iCnvY     = e.val;
            eng_made++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.oDone) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_within_budget", 32'(ok), 1);
    endtask

    task automatic wait_pix(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (pix_n >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check("pixel_reached", 32'(ok), 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},      32'(bus.oBusy), 0);
        check({tag, "_done"},      32'(bus.oDone), 0);
        check({tag, "_err"},       32'(bus.oErr), 0);
        check({tag, "_waddr"},     32'(bus.oWAddr), 0);
        check({tag, "_xaddr"},     32'(bus.oXAddr), 0);
        check({tag, "_cnvaddr"},   32'(bus.oCnvADDR), 0);
        check({tag, "_cnvw"},      bus.oCnvW, 0);
        check({tag, "_cnvwren"},   32'(bus.oCnvWren), 0);
        check({tag, "_cnvx"},      bus.oCnvX, 0);
        check({tag, "_cnvvalid"},  32'(bus.oCnvValid), 0);
        check({tag, "_yaddr"},     32'(bus.oYAddr), 0);
        check({tag, "_ydata"},     bus.oYData, 0);
        check({tag, "_ywren"},     32'(bus.oYWren), 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < KK; i++) wram[i] = int'($urandom_range(0, 255)) - 128;
        for (int p = 0; p < NPIX; p++) xram[p] = int'($urandom_range(0, 255)) - 128;
    endtask

    // Full job with a start pulse mid-STREAM (optional) and one in the DONE cycle.
    task automatic run_job(input bit mid_start);
        job_id++;
        repeat (2) @(negedge clk);
        pulse_start();
        if (mid_start) begin
            wait_pix(500);
            pulse_start();
        end
        wait_done(4000);
        pulse_start();
        repeat (4) @(negedge clk);
        check("busy_after_done_start", 32'(bus.oBusy), 0);
        check("wren_count", wren_n, KK);
        check("wren_contiguous", last_w_cyc - first_w_cyc, KK - 1);
        check("pixel_count", pix_n, NPIX);
        check("write_count", y_n, NO);
        check("last_yaddr", last_yaddr, NO - 1);
        check("done_count", done_n, 1);
        check("err_clear", 32'(bus.oErr), 0);
        check("exp_q_left", exp_q.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.iStart     = 1'b0;
        bus2.iStart    = 1'b0;
        bus2.iCnvValid = 1'b0;
        bus2.iCnvY     = '0;
        bus2.iWData    = 32'd3;
        bus2.iXData    = 32'd7;
        for (int i = 0; i < 1024; i++) begin
            wram[i] = 0;
            xram[i] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Job 1: W[i]=i+100, X ramp; hand-computed first two outputs.
        for (int i = 0; i < KK; i++) wram[i] = i + 100;
        for (int p = 0; p < NPIX; p++) xram[p] = p;
        eng_lat = 3;
        run_job(1'b1);
        check("ramp_out0", first_y, 192850);
        check("ramp_out1", second_y, 195650);

        // Job 2: random data and engine latency.
        fill_random();
        eng_lat = int'($urandom_range(1, 8));
        run_job(1'b0);

        // Job 3: engine stalls after 500 results -> watchdog.
        fill_random();
        eng_limit = 500;
        job_id++;
        repeat (2) @(negedge clk);
        pulse_start();
        wait_done(4000);
        repeat (2) @(negedge clk);
        check("wd_write_count", y_n, 500);
        check("wd_err", 32'(bus.oErr), 1);
        check("wd_done_count", done_n, 1);
        check("wd_timing", err_rise_cyc - ((last_y_cyc > last_pix_cyc) ? last_y_cyc : last_pix_cyc), TMO);

        // Job 4: next start clears oErr; reset at pixel 300.
        eng_limit = 1 << 30;
        job_id++;
        repeat (2) @(negedge clk);
        pulse_start();
        check("err_cleared_by_start", 32'(bus.oErr), 0);
        check("busy_after_start", 32'(bus.oBusy), 1);
        wait_pix(300);
        rst = 1'b1;
        @(negedge clk);
        check_idle("midrst");
        rst = 1'b0;
        @(negedge clk);

        // Job 5: full rerun after the reset.
        fill_random();
        eng_lat = int'($urandom_range(1, 8));
        run_job(1'b0);

        // STRIDE=2, 8x8 instance: results in IDLE are dropped, only 4 kept.
        bus2.iCnvValid = 1'b1;
        bus2.iCnvY     = 32'd999;
        repeat (2) @(negedge clk);
        bus2.iCnvValid = 1'b0;
        check("s2_idle_ignored", y2_n, 0);
        bus2.iStart = 1'b1;
        @(negedge clk);
        bus2.iStart = 1'b0;
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (bus2.dbg_state == DRAIN) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("s2_reached_drain", 32'(ok), 1);
        end
        for (int k = 0; k < 6; k++) begin
            bus2.iCnvValid = 1'b1;
            bus2.iCnvY     = 1000 + k;
            @(negedge clk);
        end
        bus2.iCnvValid = 1'b0;
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (done2_n > 0) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("s2_done_seen", 32'(ok), 1);
        end
        repeat (3) @(negedge clk);
        check("s2_write_count", y2_n, 4);
        check("s2_done_count", done2_n, 1);
        check("s2_wren_count", w2_n, 25);
        check("s2_pixel_count", p2_n, 64);
        check("s2_err", 32'(bus2.oErr), 0);
        check("s2_busy", 32'(bus2.oBusy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
